// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, data width, default rates and the
// bit-period helper used by the receiver, divider and future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam int DATA_BITS      = 8;
  localparam int DEFAULT_CLK_HZ = 50000000;
  localparam int DEFAULT_BAUD   = 1152000;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for a single asynchronous input; every stage
// resets to RESET_VAL so an idle-high line does not look active after reset.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling from the system clock.
// Define UART_RX_PARITY_EN to add a parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = DEFAULT_CLK_HZ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_state_t AFTER_DATA = PARITY;
`else
  localparam uart_state_t AFTER_DATA = STOP;
`endif

  logic                 rx_s;
  uart_state_t          state;
  logic [15:0]          cyc_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
`endif

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Frame state machine; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cyc_cnt      <= 16'd0;
      bit_idx      <= 3'd0;
      shift        <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cyc_cnt <= 16'd0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= 16'd0;
            bit_idx <= 3'd0;
            // A line that is high again at mid start bit was only a glitch.
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt        <= 16'd0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= AFTER_DATA;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt    <= 16'd0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= 16'd0;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              rx_parity_err <= (^shift) ^ parity_bit ^ PARITY_ODD;
`endif
            end else begin
              rx_frame_err <= 1'b1;
              state        <= BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        BREAK: begin
          // Wait out a held-low line so it reports only one error.
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cyc_cnt <= 16'd0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table vectors, hand-written corner
// sequences and randomized frames against a frame-level timing/data model.
module tb_uart_rx;

  localparam int CPB = 50000000 / 1152000;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int LAT   = 2 + CPB / 2 + (9 + PBITS) * CPB + 1;
  localparam int FRAME = (10 + PBITS) * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
  logic       perr;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .rx_parity_err (perr)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] data;
    logic       perr;
  } ev_t;

  ev_t evs [0:1023];
  int  ev_n = 0;
  int  ev_rd = 0;
  int  busy_cnt = 0;
  int  both_cnt = 0;

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid || rx_frame_err) begin
      evs[ev_n] <= '{cyc, rx_frame_err, rx_data, perr};
      ev_n <= ev_n + 1;
    end
    if (rx_busy) busy_cnt <= busy_cnt + 1;
    if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip,
                            output int start);
    start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ pflip);
`endif
    drive_bit(stop);
  endtask

  // Consume one event and compare it with the expected frame outcome.
  task automatic expect_ev(input string nm, input int start, input logic is_err,
                           input logic [7:0] d, input logic pe, output int ecyc);
    ecyc = -1;
    check({nm, "_count"}, ev_n - ev_rd, 1);
    if (ev_n > ev_rd) begin
      ecyc = evs[ev_rd].cyc;
      check({nm, "_kind"}, int'(evs[ev_rd].err), int'(is_err));
      check({nm, "_data"}, int'(evs[ev_rd].data), int'(d));
      check_rng({nm, "_latency"}, evs[ev_rd].cyc - start, LAT - 1, LAT + 1);
`ifdef UART_RX_PARITY_EN
      if (!is_err) check({nm, "_perr"}, int'(evs[ev_rd].perr), int'(pe));
`endif
    end
    ev_rd = ev_n;
  endtask

  task automatic expect_none(input string nm);
    check({nm, "_no_event"}, ev_n - ev_rd, 0);
    ev_rd = ev_n;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pflip;
    int         gap;
    logic       exp_err;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vec [0:9];

  initial begin
    int st, c0, c1, c2, b0;
    logic [7:0] last;

    vec[0] = '{8'hA5, 1'b1, 1'b0, 20, 1'b0, 8'hA5, 1'b0};
    vec[1] = '{8'h3C, 1'b0, 1'b0, 20, 1'b1, 8'hA5, 1'b0};
    vec[2] = '{8'h81, 1'b1, 1'b0, 20, 1'b0, 8'h81, 1'b0};
    vec[3] = '{8'h00, 1'b1, 1'b0, 20, 1'b0, 8'h00, 1'b0};
    vec[4] = '{8'hFF, 1'b1, 1'b0, 20, 1'b0, 8'hFF, 1'b0};
    vec[5] = '{8'h7E, 1'b0, 1'b0, 20, 1'b1, 8'hFF, 1'b0};
    vec[6] = '{8'h55, 1'b1, 1'b0, 20, 1'b0, 8'h55, 1'b0};
    vec[7] = '{8'h03, 1'b1, 1'b0, 20, 1'b0, 8'h03, 1'b0};
    vec[8] = '{8'h03, 1'b1, 1'b1, 20, 1'b0, 8'h03, 1'b1};
    vec[9] = '{8'h80, 1'b1, 1'b0, 20, 1'b0, 8'h80, 1'b0};

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", int'(rx_data), 0);
    check("reset_valid", int'(rx_valid), 0);
    check("reset_ferr", int'(rx_frame_err), 0);
    check("reset_busy", int'(rx_busy), 0);
    rst = 1'b0;
    idle(10);

    for (int i = 0; i < 10; i++) begin
      send_frame(vec[i].data, vec[i].stop, vec[i].pflip, st);
      idle(vec[i].gap);
      expect_ev($sformatf("vec%0d", i), st, vec[i].exp_err, vec[i].exp_data,
                vec[i].exp_perr, c0);
    end

    // Bad stop bit followed by a long break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, st);
    rx_in = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    idle(50);
    expect_ev("break", st, 1'b1, 8'h80, 1'b0, c0);
    check("break_data_held", int'(rx_data), 8'h80);
    send_frame(8'h81, 1'b1, 1'b0, st);
    idle(30);
    expect_ev("after_break", st, 1'b0, 8'h81, 1'b0, c0);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0, st);
    expect_ev("b2b0", st, 1'b0, 8'h00, 1'b0, c0);
    send_frame(8'hFF, 1'b1, 1'b0, st);
    expect_ev("b2b1", st, 1'b0, 8'hFF, 1'b0, c1);
    send_frame(8'h55, 1'b1, 1'b0, st);
    idle(30);
    expect_ev("b2b2", st, 1'b0, 8'h55, 1'b0, c2);
    check_rng("b2b_gap01", c1 - c0, FRAME - 1, FRAME + 1);
    check_rng("b2b_gap12", c2 - c1, FRAME - 1, FRAME + 1);

    // Short low glitch on an idle line.
    b0 = busy_cnt;
    rx_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    idle(100);
    check_rng("glitch_busy", busy_cnt - b0, 1, 23);
    expect_none("glitch");

    // Reset pulse in the middle of data bit 4.
    st = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx_in = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(rx_busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data", int'(rx_data), 0);
    check("midrst_valid", int'(rx_valid), 0);
    check("midrst_ferr", int'(rx_frame_err), 0);
    check("midrst_busy", int'(rx_busy), 0);
    rst = 1'b0;
    idle(500);
    expect_none("midrst_abort");
    send_frame(8'h7E, 1'b1, 1'b0, st);
    idle(30);
    expect_ev("after_rst", st, 1'b0, 8'h7E, 1'b0, c0);

    // Randomized frames against the frame-level model.
    last = 8'h7E;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic       bad, pf;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 5) == 0);
      pf  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 40);
      if (bad) gap = gap + 5;
      send_frame(d, !bad, pf, st);
      idle(gap);
      if (bad) begin
        expect_ev($sformatf("rnd%0d", i), st, 1'b1, last, 1'b0, c0);
      end else begin
        expect_ev($sformatf("rnd%0d", i), st, 1'b0, d, pf, c0);
        last = d;
      end
    end

    check("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
